// File: rtl/led_trail_pwm.sv
// Comet-trail PWM driver: each LED loads to a brightness on a walker strobe, then
// decays geometrically while a free-running PWM counter renders the level as duty.
module led_trail_pwm #(
  parameter int LED_W       = 8,
  parameter int PWM_W       = 8,
  parameter int DECAY_DIV   = 16,
  parameter int DECAY_SHIFT = 2
) (
  input  logic             OSC_50m,
  input  logic             FPGA_RSTn,
  input  logic [LED_W-1:0] pat_i,
  input  logic             pat_vld_i,
  input  logic [PWM_W-1:0] bright_max_i,
  output logic [LED_W-1:0] USER_LED
);

  localparam int               DIV_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);
  localparam logic [PWM_W-1:0] CNT_MAX  = '1;

  // Decay never overshoots: the step is at most the level itself, so 1 -> 0 is the floor.
  function automatic logic [PWM_W-1:0] decay_step(input logic [PWM_W-1:0] lvl);
    logic [PWM_W-1:0] step;
    step = lvl >> DECAY_SHIFT;
    if (step == '0) begin
      step = PWM_W'(1);
    end
    return lvl - step;
  endfunction

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [PWM_W-1:0] level_q [LED_W];
  logic [PWM_W-1:0] level_d [LED_W];
  logic [PWM_W-1:0] duty_q  [LED_W];
  logic [PWM_W-1:0] duty_d  [LED_W];
  logic [LED_W-1:0] led_q, led_d;
  logic             per_end;
  logic             tick;

  always_comb begin
    per_end   = (pwm_cnt_q == CNT_MAX);
    tick      = per_end && (div_q == DIV_LAST);
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    div_d     = div_q;
    if (per_end) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end
  end

  // A load strobe outranks a coincident decay tick; unselected LEDs keep fading.
  always_comb begin
    for (int i = 0; i < LED_W; i++) begin
      level_d[i] = level_q[i];
      if (pat_vld_i && pat_i[i]) begin
        level_d[i] = bright_max_i;
      end else if (tick && (level_q[i] != '0)) begin
        level_d[i] = decay_step(level_q[i]);
      end
    end
  end

  // Duty is latched only at period end so each PWM period renders one stable level.
  always_comb begin
    for (int i = 0; i < LED_W; i++) begin
      duty_d[i] = per_end ? level_q[i] : duty_q[i];
      led_d[i]  = (pwm_cnt_q < duty_q[i]);
    end
  end

  always_ff @(posedge OSC_50m or negedge FPGA_RSTn) begin
    if (!FPGA_RSTn) begin
      pwm_cnt_q <= '0;
      div_q     <= '0;
      led_q     <= '0;
      for (int i = 0; i < LED_W; i++) begin
        level_q[i] <= '0;
        duty_q[i]  <= '0;
      end
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      div_q     <= div_d;
      led_q     <= led_d;
      for (int i = 0; i < LED_W; i++) begin
        level_q[i] <= level_d[i];
        duty_q[i]  <= duty_d[i];
      end
    end
  end

  assign USER_LED = led_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: time-indexed reference model feeds a scoreboard queue,
// plus per-period high-count checks of the comet trail and reset behaviour.
module tb_led_trail_pwm;

  localparam int LED_W       = 8;
  localparam int PWM_W       = 4;
  localparam int DECAY_DIV   = 2;
  localparam int DECAY_SHIFT = 1;
  localparam int PER         = 1 << PWM_W;
  localparam int NPER        = 64;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic [LED_W-1:0] pat   = '0;
  logic             vld   = 1'b0;
  logic [PWM_W-1:0] bmax  = '0;
  logic [LED_W-1:0] led;

  always #10 clk = ~clk;

  led_trail_pwm #(
    .LED_W      (LED_W),
    .PWM_W      (PWM_W),
    .DECAY_DIV  (DECAY_DIV),
    .DECAY_SHIFT(DECAY_SHIFT)
  ) dut (
    .OSC_50m     (clk),
    .FPGA_RSTn   (rst_n),
    .pat_i       (pat),
    .pat_vld_i   (vld),
    .bright_max_i(bmax),
    .USER_LED    (led)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference model: state expressed as brightness per LED and absolute cycle index t
  // since reset release; PWM phase and decay ticks derive from t arithmetically.
  logic [LED_W-1:0] exp_q [$];
  int last_t = -1;
  int m_lvl  [LED_W];
  int m_duty [LED_W];
  int hc     [NPER][LED_W];
  int mt, mc, mstep;
  bit mper, mtick;
  logic [LED_W-1:0] me;

  always @(posedge clk) begin
    if (!rst_n) begin
      last_t = -1;
      for (int i = 0; i < LED_W; i++) begin
        m_lvl[i]  = 0;
        m_duty[i] = 0;
      end
    end else begin
      mt    = last_t + 1;
      mc    = mt % PER;
      mper  = (mc == PER - 1);
      mtick = mper && (((mt / PER) % DECAY_DIV) == DECAY_DIV - 1);
      for (int i = 0; i < LED_W; i++) begin
        me[i] = (mc < m_duty[i]);
        if (mper) m_duty[i] = m_lvl[i];
        if (vld && pat[i]) begin
          m_lvl[i] = int'(bmax);
        end else if (mtick && m_lvl[i] > 0) begin
          mstep = m_lvl[i] >> DECAY_SHIFT;
          if (mstep == 0) mstep = 1;
          m_lvl[i] = m_lvl[i] - mstep;
        end
      end
      exp_q.push_back(me);
      last_t = mt;
    end
  end

  // Monitor: compares USER_LED every cycle and tallies high cycles per PWM period.
  logic [LED_W-1:0] mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_led", 32'(led), 32'd0);
      exp_q.delete();
      for (int p = 0; p < NPER; p++)
        for (int i = 0; i < LED_W; i++) hc[p][i] = 0;
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk($sformatf("led_sb_t%0d", last_t), 32'(led), 32'(mon_e));
      if (last_t >= 0 && (last_t / PER) < NPER)
        for (int i = 0; i < LED_W; i++) hc[last_t / PER][i] += int'(led[i]);
    end
  end

  task automatic at_edge(input int e);
    int g;
    g = 0;
    while (last_t != e && g < 20000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (last_t != e) begin
      $display("FAIL at_edge: reached edge %0d, required %0d", last_t, e);
      $fatal(1, "timeline lost");
    end
  endtask

  task automatic strobe_at(input int e, input logic [LED_W-1:0] p, input logic [PWM_W-1:0] b);
    at_edge(e - 1);
    pat  = p;
    bmax = b;
    vld  = 1'b1;
    at_edge(e);
    vld  = 1'b0;
    pat  = LED_W'($urandom);
    bmax = PWM_W'($urandom);
  endtask

  task automatic hc_chk(input int p, input int i, input int exp);
    chk($sformatf("high_cnt_p%0d_led%0d", p, i), 32'(hc[p][i]), 32'(exp));
  endtask

  task automatic dark_chk(input int p);
    int s;
    s = 0;
    for (int i = 0; i < LED_W; i++) s += hc[p][i];
    chk($sformatf("dark_p%0d", p), 32'(s), 32'd0);
  endtask

  int trail [13] = '{0, 15, 15, 8, 8, 4, 4, 2, 2, 1, 1, 0, 0};

  initial begin
    #1 rst_n = 1'b0;
    // Reset held with strobes toggling: outputs must stay dark.
    repeat (4) begin
      @(posedge clk);
      #1;
      vld  = ~vld;
      pat  = LED_W'($urandom);
      bmax = PWM_W'($urandom);
    end
    vld = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    at_edge(4 * PER + 1);
    for (int p = 0; p < 4; p++) dark_chk(p);

    // Single load then free decay: 15,8,4,2,1,0 over pairs of periods.
    strobe_at(70, 8'h01, 4'd15);
    at_edge(17 * PER + 1);
    for (int p = 4; p <= 16; p++) begin
      hc_chk(p, 0, trail[p - 4]);
      for (int i = 1; i < LED_W; i++) hc_chk(p, i, 0);
    end

    // Reload landing on a decay tick must win over the decay.
    strobe_at(290, 8'h01, 4'd15);
    strobe_at(351, 8'h01, 4'd15);
    at_edge(26 * PER + 1);
    hc_chk(19, 0, 15);
    hc_chk(20, 0, 15);
    hc_chk(21, 0, 8);
    hc_chk(22, 0, 8);
    hc_chk(23, 0, 15);
    hc_chk(24, 0, 15);
    hc_chk(25, 0, 8);

    // Walking pattern: newest LED bright, older ones fading behind it.
    strobe_at(546, 8'h01, 4'd15);
    strobe_at(578, 8'h02, 4'd15);
    strobe_at(610, 8'h04, 4'd15);
    at_edge(41 * PER + 1);
    hc_chk(37, 0, 8);
    hc_chk(37, 1, 15);
    hc_chk(37, 2, 0);
    for (int p = 39; p <= 40; p++) begin
      hc_chk(p, 0, 4);
      hc_chk(p, 1, 8);
      hc_chk(p, 2, 15);
      for (int i = 3; i < LED_W; i++) hc_chk(p, i, 0);
    end

    // Zero brightness load darkens everything.
    strobe_at(674, 8'hFF, 4'd0);
    at_edge(44 * PER + 1);
    for (int i = 0; i < LED_W; i++) hc_chk(43, i, 0);

    // Mid-decay asynchronous reset.
    strobe_at(706, 8'hFF, 4'd15);
    at_edge(737);
    chk("pre_reset_led", 32'(led), 32'hFF);
    #3 rst_n = 1'b0;
    #1 chk("async_reset_led", 32'(led), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      vld  = ~vld;
      pat  = 8'hFF;
      bmax = 4'd15;
    end
    vld = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    at_edge(3 * PER + 1);
    for (int p = 0; p < 3; p++) dark_chk(p);

    // Randomized strobes, checked cycle by cycle through the scoreboard.
    repeat (600) begin
      pat  = LED_W'($urandom);
      bmax = PWM_W'($urandom);
      vld  = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
    end
    vld = 1'b0;
    repeat (2 * PER) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
